// File: rtl/prefetch_req_gen.sv
// prefetch_req_gen
// Writer side of the prefetch instruction FIFO. Issues word-aligned sequential
// fetch requests, writes in-order responses into the FIFO tagged with their PC,
// and uses a credit counter so the FIFO can never overflow. A jump flushes the
// FIFO, drops responses still in flight and restarts fetching at the target.
//
// Optional feature: define PREFETCH_ERR_HALT_EN to stop fetching after an
// errored entry is written; the next jump resumes fetching.
//
// Ports:
//   clk_i, resetb_i              clock, asynchronous active-low reset
//   clk_en_i                     global clock enable (state holds when low)
//   jump_i, jump_addr_i          redirect pulse and target ([1:0] ignored)
//   ireqvalid_o/ireqready_i      fetch request handshake
//   ireqaddr_o                   fetch address (word aligned)
//   irspvalid_i/irsprerr_i/irspdata_i  in-order fetch response
//   fifo_flush_o, fifo_wr_o      FIFO flush and write strobes
//   fifo_din_o                   FIFO entry {err, pc[31:0], instr[31:0]}
//   fifo_rd_i                    consumer pop, returns one credit
module prefetch_req_gen #(
  parameter int unsigned C_FIFO_DEPTH_X = 2,
  parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        ireqvalid_o,
  input  logic        ireqready_i,
  output logic [31:0] ireqaddr_o,
  input  logic        irspvalid_i,
  input  logic        irsprerr_i,
  input  logic [31:0] irspdata_i,
  output logic        fifo_flush_o,
  output logic        fifo_wr_o,
  output logic [64:0] fifo_din_o,
  input  logic        fifo_rd_i
);

  localparam int unsigned CNT_W = C_FIFO_DEPTH_X + 1;
  localparam int unsigned DEPTH = 2 ** C_FIFO_DEPTH_X;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;

  logic        run;
  logic        rsp_take;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        req_fire;
  logic [31:0] jump_tgt;
  logic        unused_addr_bits;

  // Low address bits of the jump target are don't-care.
  assign unused_addr_bits = ^jump_addr_i[1:0];
  assign jump_tgt         = {jump_addr_i[31:2], 2'b00};

  // A response is only meaningful while something is outstanding.
  assign rsp_take = irspvalid_i & (outst_q != '0);
  assign rsp_drop = rsp_take & (discard_q != '0);
  assign rsp_keep = rsp_take & ~rsp_drop;

  // Request is suppressed during reset so nothing is issued before release.
  assign ireqvalid_o  = resetb_i & ~jump_i & (credit_q < DEPTH_C) & run;
  assign ireqaddr_o   = addr_q;
  assign req_fire     = ireqvalid_o & ireqready_i;

  assign fifo_flush_o = resetb_i & jump_i;
  assign fifo_wr_o    = rsp_keep & ~jump_i;
  assign fifo_din_o   = {irsprerr_i, rsp_pc_q, irspdata_i};

`ifdef PREFETCH_ERR_HALT_EN
  logic run_q, run_d;

  // Halt after an errored entry lands in the FIFO; a jump resumes fetching.
  always_comb begin
    run_d = run_q;
    if (clk_en_i) begin
      if (jump_i) begin
        run_d = 1'b1;
      end else if (fifo_wr_o & irsprerr_i) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      run_q <= 1'b1;
    end else begin
      run_q <= run_d;
    end
  end

  assign run = run_q;
`else
  assign run = 1'b1;
`endif

  // Counter and address next-state logic.
  always_comb begin
    credit_d  = credit_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    rsp_pc_d  = rsp_pc_q;
    if (clk_en_i) begin
      if (jump_i) begin
        // Everything still in flight (minus a response consumed now) is stale;
        // the FIFO is flushed so only those requests keep their credits.
        outst_d   = outst_q - CNT_W'(rsp_take);
        credit_d  = outst_q - CNT_W'(rsp_take);
        discard_d = outst_q - CNT_W'(rsp_take);
        addr_d    = jump_tgt;
        rsp_pc_d  = jump_tgt;
      end else begin
        if (req_fire) begin
          addr_d = addr_q + 32'd4;
        end
        if (rsp_keep) begin
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
        outst_d   = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
        credit_d  = credit_q + CNT_W'(req_fire) - CNT_W'(fifo_rd_i)
                    - CNT_W'(rsp_drop);
        discard_d = discard_q - CNT_W'(rsp_drop);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      credit_q  <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      addr_q    <= C_RESET_VECTOR;
      rsp_pc_q  <= C_RESET_VECTOR;
    end else begin
      credit_q  <= credit_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      rsp_pc_q  <= rsp_pc_d;
    end
  end

endmodule

// File: tb/tb_prefetch_req_gen.sv
// Directed bench for prefetch_req_gen (D = 4, reset vector 0). Expected
// requests and FIFO entries are queued as stimulus is driven and popped as the
// DUT produces them.
module tb_prefetch_req_gen;

  logic        clk = 1'b0;
  logic        resetb;
  logic        clk_en;
  logic        jump;
  logic [31:0] jump_addr;
  logic        ireqvalid;
  logic        ireqready;
  logic [31:0] ireqaddr;
  logic        rspvalid;
  logic        rsperr;
  logic [31:0] rspdata;
  logic        fifo_flush;
  logic        fifo_wr;
  logic [64:0] fifo_din;
  logic        fifo_rd;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_req[$];
  logic [64:0] exp_wr[$];
  logic [31:0] nxt;

  prefetch_req_gen #(
    .C_FIFO_DEPTH_X(2),
    .C_RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i       (clk),
    .resetb_i    (resetb),
    .clk_en_i    (clk_en),
    .jump_i      (jump),
    .jump_addr_i (jump_addr),
    .ireqvalid_o (ireqvalid),
    .ireqready_i (ireqready),
    .ireqaddr_o  (ireqaddr),
    .irspvalid_i (rspvalid),
    .irsprerr_i  (rsperr),
    .irspdata_i  (rspdata),
    .fifo_flush_o(fifo_flush),
    .fifo_wr_o   (fifo_wr),
    .fifo_din_o  (fifo_din),
    .fifo_rd_i   (fifo_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: monitor handshakes mid-cycle, then step past the rising edge.
  task automatic cyc();
    logic [31:0] ea;
    logic [64:0] ew;
    @(negedge clk);
    if (clk_en && ireqvalid && ireqready) begin
      chk("req_expected", 65'(exp_req.size() != 0), 65'd1);
      if (exp_req.size() != 0) begin
        ea = exp_req.pop_front();
        chk("req_addr", 65'(ireqaddr), 65'(ea));
      end
    end
    if (fifo_wr) begin
      chk("wr_expected", 65'(exp_wr.size() != 0), 65'd1);
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        chk("wr_entry", fifo_din, ew);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0; clk_en = 1'b1; jump = 1'b0; jump_addr = '0; ireqready = 1'b0;
    rspvalid = 1'b0; rsperr = 1'b0; rspdata = '0; fifo_rd = 1'b0; nxt = '0;
    #2;
    chk("rst_valid", 65'(ireqvalid), 65'd0);
    chk("rst_addr", 65'(ireqaddr), 65'h0);
    chk("rst_wr", 65'(fifo_wr), 65'd0);
    chk("rst_flush", 65'(fifo_flush), 65'd0);
    @(posedge clk); @(posedge clk); #1;
    resetb = 1'b1;
    #1;
    chk("first_valid", 65'(ireqvalid), 65'd1);

    // Fill all four credits back to back.
    ireqready = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'hC);
    repeat (4) cyc();
    chk("full_valid", 65'(ireqvalid), 65'd0);
    repeat (2) cyc();
    chk("full_hold", 65'(ireqvalid), 65'd0);
    chk("fill_reqs_done", 65'(exp_req.size()), 65'd0);

    // Two responses written with sequential PCs.
    rspvalid = 1'b1; rspdata = 32'hAAAA_0001;
    exp_wr.push_back({1'b0, 32'h0, 32'hAAAA_0001});
    cyc();
    rspdata = 32'hAAAA_0002;
    exp_wr.push_back({1'b0, 32'h4, 32'hAAAA_0002});
    cyc();
    rspvalid = 1'b0;
    chk("rsp_writes_done", 65'(exp_wr.size()), 65'd0);
    chk("still_full", 65'(ireqvalid), 65'd0);

    // One pop frees exactly one request.
    fifo_rd = 1'b1;
    cyc();
    fifo_rd = 1'b0;
    #1;
    chk("pop_valid", 65'(ireqvalid), 65'd1);
    chk("pop_addr", 65'(ireqaddr), 65'h10);
    exp_req.push_back(32'h10);
    cyc();
    chk("pop_one_only", 65'(ireqvalid), 65'd0);

    // Jump with three outstanding: flush, restart, drop three responses.
    jump = 1'b1; jump_addr = 32'h0000_1003;
    #1;
    chk("jump_flush", 65'(fifo_flush), 65'd1);
    chk("jump_valid", 65'(ireqvalid), 65'd0);
    cyc();
    jump = 1'b0;
    #1;
    chk("tgt_valid", 65'(ireqvalid), 65'd1);
    chk("tgt_addr", 65'(ireqaddr), 65'h1000);
    exp_req.push_back(32'h1000);
    cyc();
    ireqready = 1'b0;
    rspvalid = 1'b1; rspdata = 32'hDEAD_0000;
    repeat (3) cyc();
    rspdata = 32'hBBBB_0004;
    exp_wr.push_back({1'b0, 32'h1000, 32'hBBBB_0004});
    cyc();
    rspvalid = 1'b0;
    chk("post_jump_wr_done", 65'(exp_wr.size()), 65'd0);

    // Stall: request held stable, then a jump retargets it.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 65'(ireqvalid), 65'd1);
      chk("stall_addr", 65'(ireqaddr), 65'h1004);
      cyc();
    end
    jump = 1'b1; jump_addr = 32'h0000_2000;
    #1;
    chk("stall_jump_valid", 65'(ireqvalid), 65'd0);
    cyc();
    jump = 1'b0;
    #1;
    chk("stall_tgt_valid", 65'(ireqvalid), 65'd1);
    chk("stall_tgt_addr", 65'(ireqaddr), 65'h2000);
    ireqready = 1'b1;
    exp_req.push_back(32'h2000);
    cyc();
    ireqready = 1'b0;

    // Errored response.
    rspvalid = 1'b1; rsperr = 1'b1; rspdata = 32'hEEEE_0001;
    exp_wr.push_back({1'b1, 32'h2000, 32'hEEEE_0001});
    cyc();
    rspvalid = 1'b0; rsperr = 1'b0;
    chk("err_wr_done", 65'(exp_wr.size()), 65'd0);
`ifdef PREFETCH_ERR_HALT_EN
    #1;
    chk("halt_valid", 65'(ireqvalid), 65'd0);
    ireqready = 1'b1;
    repeat (2) cyc();
    chk("halt_hold", 65'(ireqvalid), 65'd0);
    ireqready = 1'b0;
    jump = 1'b1; jump_addr = 32'h0000_0200;
    cyc();
    jump = 1'b0;
    #1;
    chk("resume_valid", 65'(ireqvalid), 65'd1);
    chk("resume_addr", 65'(ireqaddr), 65'h200);
    ireqready = 1'b1;
    exp_req.push_back(32'h200);
    cyc();
    ireqready = 1'b0;
    nxt = 32'h204;
`else
    #1;
    chk("err_continue_valid", 65'(ireqvalid), 65'd1);
    chk("err_continue_addr", 65'(ireqaddr), 65'h2004);
    ireqready = 1'b1;
    exp_req.push_back(32'h2004);
    cyc();
    ireqready = 1'b0;
    nxt = 32'h2008;
`endif

    // Clock enable low: nothing advances even though the bus is ready.
    clk_en = 1'b0; ireqready = 1'b1;
    repeat (2) cyc();
    chk("clken_addr", 65'(ireqaddr), 65'(nxt));
    chk("clken_valid", 65'(ireqvalid), 65'd1);
    clk_en = 1'b1; ireqready = 1'b0;

    // Jump near the top of memory: address and PC wrap to zero.
    jump = 1'b1; jump_addr = 32'hFFFF_FFFE;
    #1;
    chk("wrap_flush", 65'(fifo_flush), 65'd1);
    cyc();
    jump = 1'b0;
    ireqready = 1'b1;
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    cyc(); cyc();
    ireqready = 1'b0;
    rspvalid = 1'b1; rspdata = 32'h1234_5678;
    cyc();
    rspdata = 32'hCCCC_0003;
    exp_wr.push_back({1'b0, 32'hFFFF_FFFC, 32'hCCCC_0003});
    cyc();
    rspdata = 32'hCCCC_0004;
    exp_wr.push_back({1'b0, 32'h0, 32'hCCCC_0004});
    cyc();
    rspvalid = 1'b0;
    chk("wrap_wr_done", 65'(exp_wr.size()), 65'd0);

    // Response with nothing outstanding is ignored.
    rspvalid = 1'b1; rspdata = 32'h5555_5555;
    #1;
    chk("stray_rsp_wr", 65'(fifo_wr), 65'd0);
    cyc();
    rspvalid = 1'b0;

    // Simultaneous pop and accept keep credit unchanged; two more fill it.
    fifo_rd = 1'b1; ireqready = 1'b1;
    exp_req.push_back(32'h4);
    cyc();
    fifo_rd = 1'b0;
    exp_req.push_back(32'h8); exp_req.push_back(32'hC);
    cyc(); cyc();
    chk("refill_full", 65'(ireqvalid), 65'd0);
    ireqready = 1'b0;

    // Asynchronous reset mid-transaction.
    resetb = 1'b0;
    #1;
    chk("mid_rst_valid", 65'(ireqvalid), 65'd0);
    chk("mid_rst_addr", 65'(ireqaddr), 65'h0);
    chk("mid_rst_wr", 65'(fifo_wr), 65'd0);
    @(posedge clk); #1;
    resetb = 1'b1;
    #1;
    chk("rerun_valid", 65'(ireqvalid), 65'd1);
    chk("rerun_addr", 65'(ireqaddr), 65'h0);
    ireqready = 1'b1;
    exp_req.push_back(32'h0);
    cyc();
    ireqready = 1'b0;
    chk("final_req_q", 65'(exp_req.size()), 65'd0);
    chk("final_wr_q", 65'(exp_wr.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
